// File: rtl/ram_loader.sv
// ram_loader: streams program bytes into a manually-strobed RAM while holding the CPU. Rev 1.0
`default_nettype none

module ram_loader #(
   parameter int LOAD_DEPTH   = 16,
   parameter int SETUP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       manual_mode,
   output logic       manual_read,
   output logic [3:0] address,
   output logic [7:0] program_switches,
   output logic       cpu_halt,
   output logic       busy,
   output logic       done,
   output logic       aborted
);

   localparam logic [3:0] c_LAST_ADDR  = 4'(LOAD_DEPTH - 1);
   localparam logic [3:0] c_SETUP_LAST = 4'(SETUP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ENTER  = 3'd1,
      S_WAIT   = 3'd2,
      S_SETUP  = 3'd3,
      S_STROBE = 3'd4,
      S_HOLD   = 3'd5,
      S_EXIT   = 3'd6
   } state_t;

   state_t     r_state;
   logic [3:0] r_cnt;
   logic [3:0] r_addr;
   logic [7:0] r_psw;
   logic       r_ready;
   logic       r_own;
   logic       r_read;
   logic       r_busy;
   logic       r_done;
   logic       r_aborted;
   logic       w_abort;
   logic       w_exit;

   // Abort is honoured in every loading state; a strobe already issued simply completes.
   assign w_abort = abort && (r_state inside {S_ENTER, S_WAIT, S_SETUP, S_STROBE, S_HOLD});
   assign w_exit  = w_abort || ((r_state == S_HOLD) && (r_addr == c_LAST_ADDR));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_psw     <= '0;
         r_ready   <= 1'b0;
         r_own     <= 1'b0;
         r_read    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         r_read  <= 1'b0;
         r_done  <= 1'b0;
         if (w_exit) begin
            r_state <= S_EXIT;
            r_own   <= 1'b0;
            r_done  <= 1'b1;
            if (w_abort) begin
               r_aborted <= 1'b1;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_state   <= S_ENTER;
                     r_addr    <= '0;
                     r_aborted <= 1'b0;
                     r_own     <= 1'b1;
                     r_busy    <= 1'b1;
                  end
               end
               S_ENTER: begin
                  r_state <= S_WAIT;
                  r_ready <= 1'b1;
               end
               S_WAIT: begin
                  if (byte_valid) begin
                     r_psw   <= byte_data;
                     r_cnt   <= '0;
                     r_state <= S_SETUP;
                  end else begin
                     r_ready <= 1'b1;
                  end
               end
               S_SETUP: begin
                  if (r_cnt == c_SETUP_LAST) begin
                     r_state <= S_STROBE;
                     r_read  <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
               S_STROBE: begin
                  r_state <= S_HOLD;
               end
               S_HOLD: begin
                  r_addr  <= r_addr + 4'd1;
                  r_state <= S_WAIT;
                  r_ready <= 1'b1;
               end
               S_EXIT: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_own   <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign byte_ready       = r_ready;
   assign manual_mode      = r_own;
   assign cpu_halt         = r_own;
   assign manual_read      = r_read;
   assign address          = r_addr;
   assign program_switches = r_psw;
   assign busy             = r_busy;
   assign done             = r_done;
   assign aborted          = r_aborted;

endmodule

`default_nettype wire

// File: tb/tb_ram_loader.sv
// tb_ram_loader: randomized scoreboard bench for ram_loader. Rev 1.0
`default_nettype none

module tb_ram_loader;

   localparam int c_DEPTH = 16;
   localparam int c_SETUP = 3;

   logic       clk        = 1'b0;
   logic       rst_n      = 1'b1;
   logic       start      = 1'b0;
   logic       abort      = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data  = 8'h00;
   logic       byte_ready, manual_mode, manual_read, cpu_halt, busy, done, aborted;
   logic [3:0] address;
   logic [7:0] program_switches;

   ram_loader #(.LOAD_DEPTH(c_DEPTH), .SETUP_CYCLES(c_SETUP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .manual_mode(manual_mode), .manual_read(manual_read), .address(address),
      .program_switches(program_switches), .cpu_halt(cpu_halt), .busy(busy),
      .done(done), .aborted(aborted)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // The RAM the loader drives; it is never reset, so words survive a loader reset.
   logic [7:0] dut_ram [16] = '{default: 8'h00};
   always @(posedge clk) if (manual_mode && manual_read) dut_ram[address] <= program_switches;

   typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;
   wr_t        exp_q [$];
   logic [7:0] ref_ram [16];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int         acc_cyc, last_strobe_cyc, exp_done_gap, n_done;
   logic [3:0] acc_addr;
   logic [7:0] acc_data;
   bit         win_on, strobed, prev_ready, prev_done;
   wr_t        e;

   initial begin
      n_done = 0; exp_done_gap = 0; last_strobe_cyc = 0; acc_cyc = 0;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         win_on = 0; strobed = 0; prev_ready = 0; prev_done = 0;
      end else begin
         if (byte_valid && byte_ready) begin
            acc_cyc = cyc; acc_addr = address; acc_data = byte_data;
            win_on = 1; strobed = 0;
         end else if (win_on) begin
            if (cyc <= acc_cyc + c_SETUP + 2) begin
               chk("stable_addr", 32'(address), 32'(acc_addr));
               chk("stable_data", 32'(program_switches), 32'(acc_data));
            end else begin
               win_on = 0;
            end
         end
         if (manual_read) begin
            chk("strobe_time", cyc, acc_cyc + c_SETUP + 1);
            chk("strobe_owned", 32'(manual_mode), 32'd1);
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_strobe: got write addr %0d data 0x%0h, required no write (cycle %0d)",
                        address, program_switches, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("strobe_addr", 32'(address), 32'(e.a));
               chk("strobe_data", 32'(program_switches), 32'(e.d));
            end
            strobed = 1; last_strobe_cyc = cyc;
         end
         if (byte_ready && !prev_ready && strobed)
            chk("ready_return", cyc, acc_cyc + c_SETUP + 3);
         if (done) begin
            n_done++;
            chk("done_width", 32'(prev_done), 32'd0);
            if (exp_done_gap > 0) chk("done_time", cyc, last_strobe_cyc + exp_done_gap);
            win_on = 0; strobed = 0;
         end
         prev_ready = byte_ready; prev_done = done;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk_zero(input string nm);
      chk(nm, 32'({byte_ready, manual_mode, manual_read, address, program_switches,
                   cpu_halt, busy, done, aborted}), 32'd0);
   endtask

   task automatic pulse_start(input bit with_abort);
      start = 1'b1; abort = with_abort;
      tick();
      start = 1'b0; abort = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      bit got;
      got = 0;
      byte_valid = 1'b1; byte_data = d;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (byte_ready) begin got = 1; break; end
      end
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: got byte_ready=0, required 1 within 200 cycles");
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask

   task automatic load_bytes(input int first, input int n, input bit rnd, input bit gaps);
      logic [7:0] d;
      wr_t w;
      for (int i = first; i < first + n; i++) begin
         d = rnd ? 8'($urandom) : 8'(8'h10 + i);
         w.a = 4'(i); w.d = d;
         exp_q.push_back(w);
         ref_ram[i] = d;
         if (gaps) repeat ($urandom_range(0, 3)) tick();
         send(d);
      end
   endtask

   task automatic wait_done();
      bit got;
      got = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (done) begin got = 1; break; end
      end
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL done_timeout: got done=0, required 1 within 300 cycles");
      end
      tick();
   endtask

   task automatic compare_ram(input string nm);
      for (int i = 0; i < 16; i++) chk(nm, 32'(dut_ram[i]), 32'(ref_ram[i]));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ref_ram[i] = 8'h00;
      #1 rst_n = 1'b0;
      #2 chk_zero("reset_async");
      #20;
      rst_n = 1'b1;
      tick();
      chk_zero("reset_idle");

      // Full load of 0x10..0x1F with the source always valid.
      exp_done_gap = 2;
      pulse_start(1'b0);
      load_bytes(0, c_DEPTH, 1'b0, 1'b0);
      wait_done();
      chk("full_aborted", 32'(aborted), 32'd0);
      chk("full_busy_idle", 32'(busy), 32'd0);
      compare_ram("full_readback");

      // Stalled source, plus a start pulse that must be ignored mid-load.
      pulse_start(1'b0);
      load_bytes(0, 2, 1'b1, 1'b0);
      repeat (c_SETUP + 3) tick();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_ready", 32'(byte_ready), 32'd1);
         chk("stall_mode", 32'(manual_mode), 32'd1);
         chk("stall_halt", 32'(cpu_halt), 32'd1);
         chk("stall_no_strobe", 32'(manual_read), 32'd0);
         start = (i == 4);
      end
      start = 1'b0;
      load_bytes(2, c_DEPTH - 2, 1'b1, 1'b1);
      wait_done();
      chk("stall_aborted", 32'(aborted), 32'd0);
      compare_ram("stall_readback");

      // Abort during SETUP of the word at address 4.
      exp_done_gap = 0;
      pulse_start(1'b0);
      load_bytes(0, 4, 1'b1, 1'b0);
      send(8'($urandom));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_done();
      chk("setup_abort_flag", 32'(aborted), 32'd1);
      chk("setup_abort_mode", 32'(manual_mode), 32'd0);
      compare_ram("setup_abort_ram");

      // start and abort together in IDLE: start wins. Then abort in STROBE at address 2.
      exp_done_gap = 1;
      pulse_start(1'b1);
      chk("start_wins_aborted", 32'(aborted), 32'd0);
      chk("start_wins_busy", 32'(busy), 32'd1);
      load_bytes(0, 3, 1'b1, 1'b0);
      begin
         bit seen;
         seen = 0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (manual_read) begin seen = 1; break; end
         end
         chk("strobe_seen_before_abort", 32'(seen), 32'd1);
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      wait_done();
      chk("strobe_abort_flag", 32'(aborted), 32'd1);
      compare_ram("strobe_abort_ram");

      // Reset asserted during SETUP of address 7, then a complete reload.
      exp_done_gap = 0;
      pulse_start(1'b0);
      load_bytes(0, 7, 1'b1, 1'b0);
      send(8'($urandom));
      #3 rst_n = 1'b0;
      #1 chk_zero("reset_midload");
      #12 rst_n = 1'b1;
      tick();
      compare_ram("reset_retained");
      exp_done_gap = 2;
      pulse_start(1'b0);
      load_bytes(0, c_DEPTH, 1'b1, 1'b1);
      wait_done();
      chk("reload_aborted", 32'(aborted), 32'd0);
      compare_ram("reload_readback");

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("done_count", 32'(n_done), 32'd5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion, required finish before 200000 time units");
      $fatal(1, "simulation timeout");
   end

endmodule

`default_nettype wire

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter LOAD_DEPTH, default 16: number of RAM words written per load, legal range 1..16.
REQ-002 Parameter SETUP_CYCLES, default 1: cycles address/data are held stable before the write strobe, legal range 1..15.
REQ-003 clk  in  1  rising-edge system clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 abort  in  1  terminate the load in progress without further writes.
REQ-007 byte_valid  in  1  program byte available on byte_data.
REQ-008 byte_data  in  8  program byte.
REQ-009 byte_ready  out  1  loader accepts byte_data this cycle; a transfer occurs when byte_valid&byte_ready.
REQ-010 manual_mode  out  1  drives the RAM manual_mode input; RAM is owned by the loader while high.
REQ-011 manual_read  out  1  one-cycle RAM write strobe; RAM captures program_switches at address.
REQ-012 address  out  4  RAM word address.
REQ-013 program_switches  out  8  data presented to the RAM.
REQ-014 cpu_halt  out  1  holds the CPU clock-enable low while a load is in progress.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse on completion or abort.
REQ-017 aborted  out  1  sticky; set on abort, cleared by the next accepted start.

Function
REQ-018 FSM states: IDLE, ENTER, WAIT_BYTE, SETUP, STROBE, HOLD, EXIT.
REQ-019 IDLE: start=1 -> ENTER; address cleared to 0; aborted cleared.
REQ-020 ENTER: one cycle; manual_mode and cpu_halt rise on entry -> WAIT_BYTE.
REQ-021 manual_mode and cpu_halt: high in ENTER, WAIT_BYTE, SETUP, STROBE, HOLD; low in IDLE and EXIT.
REQ-022 WAIT_BYTE: byte_ready=1, registered high; on byte_valid, byte_data is captured into program_switches -> SETUP.
REQ-023 byte_ready: low in all states except WAIT_BYTE; no byte is accepted outside WAIT_BYTE.
REQ-024 SETUP: lasts exactly SETUP_CYCLES cycles, counted by an internal 4-bit counter -> STROBE.
REQ-025 STROBE: exactly one cycle; manual_read=1 -> HOLD.
REQ-026 manual_read: high only in STROBE; never high twice for one byte.
REQ-027 Stability: address and program_switches are unchanged from the first SETUP cycle through the HOLD cycle.
REQ-028 HOLD: one cycle, manual_read=0.
REQ-029 HOLD exit when address==LOAD_DEPTH-1: go to EXIT with address unchanged.
REQ-030 HOLD exit otherwise: address increments by 1 and the FSM returns to WAIT_BYTE.
REQ-031 Cycle timing: byte accepted in cycle t; manual_read at cycle t+SETUP_CYCLES+1; byte_ready high again at t+SETUP_CYCLES+3.
REQ-032 EXIT: one cycle; done=1 -> IDLE.
REQ-033 abort in WAIT_BYTE, SETUP or HOLD: next state EXIT, aborted set, no further manual_read.
REQ-034 abort in ENTER: next state EXIT, aborted set, no further manual_read.
REQ-035 abort in STROBE: the strobe completes; next state EXIT, not HOLD; aborted set.
REQ-036 abort and start both high in IDLE: start wins; abort is ignored in IDLE and EXIT.
REQ-037 start outside IDLE is ignored; no queuing.
REQ-038 Address wrap: address never exceeds LOAD_DEPTH-1 and never wraps within one load.

Reset
REQ-039 rst_n low: immediately, without waiting for clk, state=IDLE; manual_mode, manual_read, cpu_halt, byte_ready, busy, done and aborted = 0; address=0; program_switches=0.
REQ-040 Reset asserted mid-load drops manual_mode and manual_read the same instant; the RAM retains words already written.
REQ-041 First state transition after reset occurs on the first rising clk edge with rst_n high.

Verification
REQ-042 Full load: start, then 16 bytes 0x10..0x1F with byte_valid always high -> 16 strobes at addresses 0..15 with matching data; done one cycle after the last HOLD; RAM readback equals the stream.
REQ-043 Timing: SETUP_CYCLES=3, byte accepted at cycle t -> manual_read at t+4 only; address/data stable t+1..t+5; byte_ready high at t+6.
REQ-044 Stalled source: byte_valid low for 10 cycles in WAIT_BYTE -> no strobe, byte_ready held 1, manual_mode held 1.
REQ-045 Abort: abort asserted in SETUP of byte 5 (address 4) -> no strobe at address 4; done pulses; aborted=1; RAM words 0..3 written, 4..15 unchanged.
REQ-046 Abort in STROBE at address 2 -> word 2 written; EXIT follows; aborted=1.
REQ-047 Reset mid-load: rst_n low during SETUP at address 7 -> all outputs 0 asynchronously; a new start reloads from address 0.
